integrator_sample_router: RTL and testbench
===========================================

Name: integrator_sample_router

Overview:
- Upstream feeder of the threshold integrator.
- Accepts a single stream of channel-tagged 16-bit offset-binary samples from the ADC/DAC sample core.
- Demultiplexes the stream into the 8×16 concatenated value bus plus per-channel one-cycle ready strobes.
- Issues the "sample core done" qualifier once a complete first frame is captured, and polices frame integrity (duplicate channels, stalled stream).

Parameters:
- STALE_LIMIT, 4096, max cycles allowed between frame completions while RUNNING; must be ≥ 8.
- TIMER_WIDTH, 16, width of the frame watchdog counter; must satisfy 2^TIMER_WIDTH > STALE_LIMIT.

Ports:
- clk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- enable  in  1  level; arm/run request
- s_tdata  in  16  sample word, offset binary
- s_tchan  in  3  channel index of s_tdata
- s_tvalid  in  1  upstream valid
- s_tready  out  1  accept
- value_in_concat  out  128  channel i at bits [16i+15:16i]
- value_ready_concat  out  8  per-channel one-cycle update strobe
- sample_core_done  out  1  level; first full frame captured
- frame_done  out  1  one-cycle pulse per completed frame
- err_sequence  out  1  sticky; duplicate channel within a frame
- err_stale  out  1  sticky; watchdog expired

Behaviour:
- Reset and clock: reset is aresetn, synchronous, active-low; clock is clk.
- Reset values:
  - every value_in_concat slice = 16'h8000 (mid-scale, zero magnitude);
  - all other outputs 0;
  - seen_mask = 0, watchdog = 0, state = IDLE.
- Handshake:
  - A beat is accepted when s_tvalid & s_tready.
  - s_tready = 1 only in ARMED and RUNNING; 0 in IDLE and FAULT.
  - Back-to-back beats every cycle are supported; no internal buffering.
- Latency: beat accepted at cycle N → slice s_tchan updated and (in RUNNING) value_ready_concat[s_tchan] high at N+1 only.
- Frame tracking: 8-bit seen_mask.
  - On an accepted beat, if seen_mask[s_tchan] is already set → sequence error.
  - Otherwise set the bit.
  - When the beat completes all 8 bits: seen_mask clears to 0 and frame_done pulses at N+1.
  - Channel order within a frame is free.
- States:
  - IDLE: enable=1 → ARMED.
  - ARMED: store values and track frames, with no ready strobes. First frame completion → sample_core_done=1 and RUNNING (same edge as the frame_done pulse). enable=0 → IDLE.
  - RUNNING:
    - store, strobe and track frames;
    - watchdog increments every cycle and clears on frame completion;
    - watchdog == STALE_LIMIT → err_stale=1, FAULT;
    - enable=0 → IDLE, sample_core_done=0, seen_mask cleared, stored slices retained.
  - FAULT: s_tready=0, no strobes, all outputs frozen; exit only via reset.
- Sequence error: sets err_sequence=1 and enters FAULT from ARMED or RUNNING. The offending beat is still written to its slice but never strobed.
- Simultaneous events:
  - Duplicate on the beat that would complete a frame: the error wins, and there is no frame_done.
  - Frame completion in the same cycle the watchdog reaches STALE_LIMIT: completion wins and the watchdog clears.
  - enable falling in the same cycle as an accepted beat: the beat is stored, no strobe is issued, and the next state is IDLE.
- Reset mid-operation: returns immediately to reset values on the next edge, including mid-scale slices and cleared sticky errors.

Optional Feature:
- Macro: SAMPLE_TWOS_COMP_EN.
- Defined: s_tdata is two's complement, and bit 15 is inverted before storage, converting to offset binary (16'h0000 → 16'h8000).
- Undefined: s_tdata is stored unmodified.

Decomposition:
- Shared package (integrator_pkg):
  - state encoding (IDLE, ARMED, RUNNING, FAULT);
  - NUM_CHANNELS=8, SAMPLE_WIDTH=16, CHAN_WIDTH=3, MIDSCALE=16'h8000.
- One sub-module: sample_stale_watchdog.
  - Inputs: clk, aresetn, run, clear.
  - Output: expired.
  - Parameterised by STALE_LIMIT and TIMER_WIDTH.

Test Plan:
- Reset, enable=1, send channels 0..7 with data 16'h8000+i → sample_core_done rises one cycle after channel 7 is accepted; no value_ready_concat strobes during ARMED.
- RUNNING, send chan 3 data 16'hC000 at cycle N → value_in_concat[63:48]=16'hC000 and value_ready_concat=8'h08 at N+1 only.
- RUNNING, send channels in order 5,2,7,0,1,3,4,6 → exactly one frame_done pulse, one cycle after channel 6 is accepted.
- RUNNING, send chan 4 twice within one frame → err_sequence=1, s_tready=0 the next cycle, no strobe for the duplicate beat.
- STALE_LIMIT=64, complete a frame, then hold s_tvalid=0 → err_stale=1 exactly 64 cycles after frame_done; state sticks until aresetn=0.
- With SAMPLE_TWOS_COMP_EN defined, send chan 0 data 16'hFFFF → slice 0 reads 16'h7FFF.

Source files
------------

// File: rtl/integrator_pkg.sv
// Shared definitions for the threshold-integrator sample front end.
// Optional build macro SAMPLE_TWOS_COMP_EN: incoming samples are two's
// complement and get converted to offset binary before storage.
package integrator_pkg;

    localparam int NUM_CHANNELS = 8;
    localparam int SAMPLE_WIDTH = 16;
    localparam int CHAN_WIDTH   = 3;

    localparam logic [SAMPLE_WIDTH-1:0] MIDSCALE = 16'h8000;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ARMED   = 2'd1;
    localparam state_t ST_RUNNING = 2'd2;
    localparam state_t ST_FAULT   = 2'd3;

    // Map an incoming sample word onto the offset-binary format stored in the value bus.
    function automatic logic [SAMPLE_WIDTH-1:0] to_offset_binary(input logic [SAMPLE_WIDTH-1:0] d);
`ifdef SAMPLE_TWOS_COMP_EN
        return {~d[SAMPLE_WIDTH-1], d[SAMPLE_WIDTH-2:0]};
`else
        return d;
`endif
    endfunction

endpackage

// File: rtl/integrator_sample_router_if.sv
// Channel-tagged sample stream between the sample core and the router.
interface integrator_sample_router_if;
    import integrator_pkg::*;

    logic [SAMPLE_WIDTH-1:0] s_tdata;
    logic [CHAN_WIDTH-1:0]   s_tchan;
    logic                    s_tvalid;
    logic                    s_tready;

    modport master (output s_tdata, output s_tchan, output s_tvalid, input  s_tready);
    modport slave  (input  s_tdata, input  s_tchan, input  s_tvalid, output s_tready);

endinterface

// File: rtl/sample_stale_watchdog.sv
// Frame watchdog: counts cycles while run is high, restarts on clear.
// expired flags the cycle in which the count would step onto STALE_LIMIT.
module sample_stale_watchdog #(
    parameter int STALE_LIMIT = 4096,
    parameter int TIMER_WIDTH = 16
) (
    input  logic clk,
    input  logic aresetn,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam logic [TIMER_WIDTH-1:0] LAST_SAFE = TIMER_WIDTH'(STALE_LIMIT - 1);

    logic [TIMER_WIDTH-1:0] count;

    // Count cycles since the last frame completion; clear takes priority.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= count + TIMER_WIDTH'(1);
        end
    end

    assign expired = run && (count == LAST_SAFE);

endmodule

// File: rtl/integrator_sample_router.sv
// Demultiplexes a channel-tagged sample stream onto the 8x16 value bus,
// raises per-channel update strobes, qualifies the first complete frame
// and polices frame integrity (duplicate channel, stalled stream).
// Optional build macro SAMPLE_TWOS_COMP_EN (see integrator_pkg).
module integrator_sample_router
    import integrator_pkg::*;
#(
    parameter int STALE_LIMIT = 4096,
    parameter int TIMER_WIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 aresetn,
    input  logic                                 enable,
    integrator_sample_router_if.slave            s_stream,
    output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] value_in_concat,
    output logic [NUM_CHANNELS-1:0]              value_ready_concat,
    output logic                                 sample_core_done,
    output logic                                 frame_done,
    output logic                                 err_sequence,
    output logic                                 err_stale
);

    state_t                                     state;
    logic [NUM_CHANNELS-1:0]                    seen_mask;
    logic [NUM_CHANNELS-1:0][SAMPLE_WIDTH-1:0]  slices;

    logic                    tready;
    logic                    accept;
    logic [NUM_CHANNELS-1:0] chan_onehot;
    logic                    duplicate;
    logic                    complete;
    logic                    wd_expired;

    assign tready            = (state == ST_ARMED) || (state == ST_RUNNING);
    assign s_stream.s_tready = tready;
    assign accept            = s_stream.s_tvalid && tready;
    assign chan_onehot       = NUM_CHANNELS'(1) << s_stream.s_tchan;
    assign duplicate         = accept && ((seen_mask & chan_onehot) != '0);
    assign complete          = accept && !duplicate && (&(seen_mask | chan_onehot));
    assign value_in_concat   = slices;

    sample_stale_watchdog #(
        .STALE_LIMIT (STALE_LIMIT),
        .TIMER_WIDTH (TIMER_WIDTH)
    ) u_watchdog (
        .clk     (clk),
        .aresetn (aresetn),
        .run     (state == ST_RUNNING),
        .clear   (complete || (state == ST_IDLE)),
        .expired (wd_expired)
    );

    // Sample storage, frame tracking and the arm/run/fault sequencing.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state              <= ST_IDLE;
            seen_mask          <= '0;
            // NOTE: the slices are plain flops, not a RAM, so they can and do reset to mid-scale.
            slices             <= {NUM_CHANNELS{MIDSCALE}};
            value_ready_concat <= '0;
            sample_core_done   <= 1'b0;
            frame_done         <= 1'b0;
            err_sequence       <= 1'b0;
            err_stale          <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every decision below sees pre-edge values.
            value_ready_concat <= '0;
            frame_done         <= 1'b0;

            if (accept) begin
                slices[s_stream.s_tchan] <= to_offset_binary(s_stream.s_tdata);
            end

            case (state)
                ST_IDLE: begin
                    if (enable) state <= ST_ARMED;
                end
                ST_ARMED, ST_RUNNING: begin
                    if (duplicate) begin
                        err_sequence <= 1'b1;
                        state        <= ST_FAULT;
                    end else if (!enable) begin
                        state            <= ST_IDLE;
                        seen_mask        <= '0;
                        sample_core_done <= 1'b0;
                    end else begin
                        if (accept && (state == ST_RUNNING)) value_ready_concat <= chan_onehot;
                        if (complete) begin
                            seen_mask        <= '0;
                            frame_done       <= 1'b1;
                            sample_core_done <= 1'b1;
                            state            <= ST_RUNNING;
                        end else begin
                            if (accept) seen_mask <= seen_mask | chan_onehot;
                            if (wd_expired) begin
                                err_stale <= 1'b1;
                                state     <= ST_FAULT;
                            end
                        end
                    end
                end
                default: begin
                    // Fault: everything frozen until reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_integrator_sample_router.sv
// Self-checking bench for integrator_sample_router: directed vector table,
// hand-written corner sequences and randomized traffic against a model.
module tb_integrator_sample_router;
    import integrator_pkg::*;

    localparam int STALE = 64;

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic         enable = 1'b0;
    logic [127:0] value_in_concat;
    logic [7:0]   value_ready_concat;
    logic         sample_core_done;
    logic         frame_done;
    logic         err_sequence;
    logic         err_stale;

    integrator_sample_router_if bus ();

    integrator_sample_router #(
        .STALE_LIMIT (STALE),
        .TIMER_WIDTH (16)
    ) dut (
        .clk                (clk),
        .aresetn            (aresetn),
        .enable             (enable),
        .s_stream           (bus.slave),
        .value_in_concat    (value_in_concat),
        .value_ready_concat (value_ready_concat),
        .sample_core_done   (sample_core_done),
        .frame_done         (frame_done),
        .err_sequence       (err_sequence),
        .err_stale          (err_stale)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [15:0] m_val [8];
    bit          m_seen [8];
    bit          m_armed, m_running, m_fault;
    int          m_wd;
    logic [7:0]  m_strobe;
    bit          m_fd, m_core, m_eseq, m_estale;

    function automatic logic [15:0] expect_store(input logic [15:0] d);
`ifdef SAMPLE_TWOS_COMP_EN
        return d ^ 16'h8000;
`else
        return d;
`endif
    endfunction

    function automatic bit all_seen();
        for (int i = 0; i < 8; i++) if (!m_seen[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_seen();
        for (int i = 0; i < 8; i++) m_seen[i] = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_val[i] = 16'h8000;
        clear_seen();
        m_armed = 0; m_running = 0; m_fault = 0; m_wd = 0;
        m_strobe = '0; m_fd = 0; m_core = 0; m_eseq = 0; m_estale = 0;
    endtask

    function automatic bit model_ready();
        return (m_armed || m_running) && !m_fault;
    endfunction

    task automatic model_step(input logic en, input logic v, input logic [2:0] ch, input logic [15:0] d);
        m_strobe = '0;
        m_fd     = 0;
        if (m_fault) return;
        if (!m_armed && !m_running) begin
            m_armed = en;
            return;
        end
        if (v) begin
            m_val[ch] = expect_store(d);
            if (m_seen[ch]) begin
                m_eseq  = 1;
                m_fault = 1;
                return;
            end
            m_seen[ch] = 1;
        end
        if (!en) begin
            m_armed = 0; m_running = 0; m_core = 0;
            clear_seen();
            return;
        end
        if (v && m_running) m_strobe[ch] = 1'b1;
        if (v && all_seen()) begin
            clear_seen();
            m_fd = 1; m_core = 1; m_armed = 0; m_running = 1; m_wd = 0;
            return;
        end
        if (m_running) begin
            m_wd++;
            if (m_wd >= STALE) begin
                m_estale = 1;
                m_fault  = 1;
            end
        end
    endtask

    task automatic compare_model();
        logic [127:0] packed_vals;
        for (int i = 0; i < 8; i++) packed_vals[16*i +: 16] = m_val[i];
        check("values", value_in_concat, packed_vals);
        check("strobes", {120'd0, value_ready_concat}, {120'd0, m_strobe});
        check("flags fd/core/eseq/estale", {124'd0, frame_done, sample_core_done, err_sequence, err_stale},
              {124'd0, m_fd, m_core, m_eseq, m_estale});
    endtask

    // One clock cycle of stimulus: apply inputs after the falling edge,
    // step the model with the pre-edge state, compare after the rising edge.
    task automatic drive(input logic en, input logic v, input logic [2:0] ch, input logic [15:0] d);
        @(negedge clk);
        enable       = en;
        bus.s_tvalid = v;
        bus.s_tchan  = ch;
        bus.s_tdata  = d;
        #1;
        check("s_tready", {127'd0, bus.s_tready}, {127'd0, model_ready()});
        model_step(en, v && model_ready(), ch, d);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        aresetn      = 1'b0;
        enable       = 1'b0;
        bus.s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        compare_model();
        check("reset s_tready", {127'd0, bus.s_tready}, 128'd0);
        @(negedge clk);
        aresetn = 1'b1;
    endtask

    task automatic send_frame(input logic [15:0] base);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 3'(i), base + 16'(i));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        en;
        logic        v;
        logic [2:0]  ch;
        logic [15:0] d;
        logic [7:0]  exp_strobe;
        logic        exp_fd;
        logic        exp_core;
    } vec_t;

    function automatic vec_t mk(input logic en, input logic v, input int ch, input logic [15:0] d,
                                input logic [7:0] st, input logic fd, input logic core);
        vec_t r;
        r.en = en; r.v = v; r.ch = 3'(ch); r.d = d;
        r.exp_strobe = st; r.exp_fd = fd; r.exp_core = core;
        return r;
    endfunction

    initial begin
        vec_t tbl[$];
        int   order[8]  = '{5, 2, 7, 0, 1, 3, 4, 6};
        int   rest[7]   = '{0, 1, 2, 4, 5, 6, 7};
        int   k;
        int   quiet;
        logic [15:0] exp_word;

        bus.s_tvalid = 1'b0;
        bus.s_tchan  = '0;
        bus.s_tdata  = '0;

        // Arm, first frame in order (no strobes while armed), then running traffic.
        tbl.push_back(mk(1, 0, 0, 16'h0000, 8'h00, 0, 0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 1, i, 16'h8000 + 16'(i), 8'h00, i == 7, i == 7));
        tbl.push_back(mk(1, 1, 3, 16'hC000, 8'h08, 0, 1));
        tbl.push_back(mk(1, 0, 3, 16'h0000, 8'h00, 0, 1));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(1, 1, rest[i], 16'h1000 * 16'(rest[i]) + 16'h0011, 8'(1 << rest[i]), rest[i] == 7, 1));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 1, order[i], 16'h4000 + 16'(order[i]), 8'(1 << order[i]), order[i] == 6, 1));

        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].v, tbl[i].ch, tbl[i].d);
            check($sformatf("tbl[%0d] strobe", i), {120'd0, value_ready_concat}, {120'd0, tbl[i].exp_strobe});
            check($sformatf("tbl[%0d] frame_done", i), {127'd0, frame_done}, {127'd0, tbl[i].exp_fd});
            check($sformatf("tbl[%0d] core_done", i), {127'd0, sample_core_done}, {127'd0, tbl[i].exp_core});
            if (tbl[i].v)
                check($sformatf("tbl[%0d] slice", i), {112'd0, value_in_concat[16*tbl[i].ch +: 16]},
                      {112'd0, expect_store(tbl[i].d)});
        end

        // Duplicate channel within a frame: error, fault, no strobe, beat still stored.
        drive(1, 1, 4, 16'h1234);
        check("dup first strobe", {120'd0, value_ready_concat}, {120'd0, 8'h10});
        drive(1, 1, 4, 16'h5678);
        check("dup strobe", {120'd0, value_ready_concat}, 128'd0);
        check("dup err_sequence", {127'd0, err_sequence}, {127'd0, 1'b1});
        check("dup slice", {112'd0, value_in_concat[79:64]}, {112'd0, expect_store(16'h5678)});
        #1;
        check("dup s_tready", {127'd0, bus.s_tready}, 128'd0);
        for (int i = 0; i < 3; i++) drive(1, 1, 3'(i), 16'hDEAD);

        // Stale watchdog: err_stale exactly STALE cycles after frame_done.
        do_reset();
        check("reset err_sequence", {127'd0, err_sequence}, 128'd0);
        drive(1, 0, 0, 16'h0);
        send_frame(16'h2000);
        check("stale frame_done", {127'd0, frame_done}, {127'd0, 1'b1});
        k = 0;
        for (int i = 1; i <= 100; i++) begin
            drive(1, 0, 0, 16'h0);
            if (err_stale) begin
                k = i;
                break;
            end
        end
        check("stale delay", 128'(k), 128'(STALE));
        for (int i = 0; i < 4; i++) drive(1, 1, 3'(i), 16'hBEEF);
        check("stale sticky", {127'd0, err_stale}, {127'd0, 1'b1});
        do_reset();
        check("reset err_stale", {127'd0, err_stale}, 128'd0);
        check("reset midscale", value_in_concat, {8{16'h8000}});

        // Frame completion on the cycle the watchdog would expire: completion wins.
        drive(1, 0, 0, 16'h0);
        send_frame(16'h3000);
        for (int i = 0; i < STALE - 8; i++) drive(1, 0, 0, 16'h0);
        send_frame(16'h3100);
        check("boundary frame_done", {127'd0, frame_done}, {127'd0, 1'b1});
        check("boundary no stale", {127'd0, err_stale}, 128'd0);
        drive(1, 0, 0, 16'h0);
        check("boundary still running", {127'd0, err_stale}, 128'd0);

        // Enable falls with an accepted beat: stored, no strobe, back to idle.
        drive(0, 1, 2, 16'hAAAA);
        check("en-fall strobe", {120'd0, value_ready_concat}, 128'd0);
        check("en-fall slice", {112'd0, value_in_concat[47:32]}, {112'd0, expect_store(16'hAAAA)});
        check("en-fall core_done", {127'd0, sample_core_done}, 128'd0);
        #1;
        check("en-fall s_tready", {127'd0, bus.s_tready}, 128'd0);

        // Sample format conversion on slice 0.
        do_reset();
        drive(1, 0, 0, 16'h0);
        drive(1, 1, 0, 16'hFFFF);
`ifdef SAMPLE_TWOS_COMP_EN
        exp_word = 16'h7FFF;
`else
        exp_word = 16'hFFFF;
`endif
        check("format slice0", {112'd0, value_in_concat[15:0]}, {112'd0, exp_word});

        // Randomized traffic against the model.
        do_reset();
        quiet = 0;
        for (int n = 0; n < 2000; n++) begin
            logic        en, v;
            logic [2:0]  ch;
            int          free[$];
            if (m_fault && $urandom_range(0, 7) == 0) do_reset();
            if (quiet == 0 && $urandom_range(0, 59) == 0) quiet = int'($urandom_range(30, 80));
            en = ($urandom_range(0, 149) != 0);
            v  = (quiet == 0) && ($urandom_range(0, 3) != 0);
            if (quiet > 0) quiet--;
            free.delete();
            for (int c = 0; c < 8; c++) if (!m_seen[c]) free.push_back(c);
            if ($urandom_range(0, 59) == 0 || free.size() == 0)
                ch = 3'($urandom_range(0, 7));
            else
                ch = 3'(free[$urandom_range(0, free.size() - 1)]);
            drive(en, v, ch, 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
